mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 2**SELECT_WIDTH-input word mux. It shares one output channel between N = 2**SELECT_WIDTH requesters. Each requester uses a valid/ready handshake and sends multi-beat bursts delimited by a last flag. The block drives the mux selector from its grant index and registers the selected word into a one-deep output stage with a valid/ready handshake toward the consumer.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/word_mux.sv | 20 ++
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared types and helpers for the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    // Arbiter sequencing state: free to pick, or locked to one burst owner.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Modulo-n increment; n is the requester count.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority finder. Returns the first set
//               request bit searching ptr_i, ptr_i+1, ... modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int SELECT_WIDTH = 5
) (
    input  logic [(2**SELECT_WIDTH)-1:0] req_i,
    input  logic [SELECT_WIDTH-1:0]      ptr_i,
    output logic                         found_o,
    output logic [SELECT_WIDTH-1:0]      idx_o
);
    localparam int N = 2**SELECT_WIDTH;

    // Walk the request vector starting at the pointer; index arithmetic wraps
    // naturally because N is a power of two.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_i[ptr_i + SELECT_WIDTH'(k)]) begin
                found_o = 1'b1;
                idx_o   = ptr_i + SELECT_WIDTH'(k);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/word_mux.sv
`default_nettype none
// ============================================================================
// Module      : word_mux
// Description : 2**SELECT_WIDTH-input word multiplexer, one W-bit word per
//               input, selected by sel_i.
// Revision    : 1.0 - initial release
// ============================================================================
module word_mux #(
    parameter int SELECT_WIDTH = 5,
    parameter int DATA_WIDTH   = 5
) (
    input  logic [(2**DATA_WIDTH)-1:0] data_i [(2**SELECT_WIDTH)-1:0],
    input  logic [SELECT_WIDTH-1:0]    sel_i,
    output logic [(2**DATA_WIDTH)-1:0] data_o
);
    // Pure selection; no registering here.
    assign data_o = data_i[sel_i];

endmodule : word_mux
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin burst arbiter in front of the word mux, with a
//               one-deep registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SELECT_WIDTH = 5,
    parameter int DATA_WIDTH   = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [(2**SELECT_WIDTH)-1:0] req_valid_i,
    input  logic [(2**SELECT_WIDTH)-1:0] req_last_i,
    input  logic [(2**DATA_WIDTH)-1:0]   req_data_i [(2**SELECT_WIDTH)-1:0],
    output logic [(2**SELECT_WIDTH)-1:0] req_ready_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [(2**DATA_WIDTH)-1:0]   out_data_o,
    output logic [SELECT_WIDTH-1:0]      out_src_o,
    output logic                         out_last_o,
    output logic                         busy_o
);
    localparam int unsigned N = 2**SELECT_WIDTH;
    localparam int          W = 2**DATA_WIDTH;

    arb_state_e                r_state_q,    w_state_d;
    logic [SELECT_WIDTH-1:0]   r_ptr_q,      w_ptr_d;
    logic [SELECT_WIDTH-1:0]   r_lock_idx_q, w_lock_idx_d;
    logic                      r_out_valid_q;
    logic [W-1:0]              r_out_data_q;
    logic [SELECT_WIDTH-1:0]   r_out_src_q;
    logic                      r_out_last_q;

    logic                      w_pick_found;
    logic [SELECT_WIDTH-1:0]   w_pick_idx;
    logic [SELECT_WIDTH-1:0]   w_grant_idx;
    logic                      w_can_accept;
    logic                      w_grant_en;
    logic                      w_xfer;
    logic                      w_xfer_last;
    logic [W-1:0]              w_mux_data;

    rr_pick #(
        .SELECT_WIDTH (SELECT_WIDTH)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (r_ptr_q),
        .found_o (w_pick_found),
        .idx_o   (w_pick_idx)
    );

    word_mux #(
        .SELECT_WIDTH (SELECT_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_mux (
        .data_i (req_data_i),
        .sel_i  (w_grant_idx),
        .data_o (w_mux_data)
    );

    // The output register can take a beat if empty or draining this cycle.
    assign w_can_accept = !r_out_valid_q || out_ready_i;
    assign w_grant_idx  = (r_state_q == ARB_LOCKED) ? r_lock_idx_q : w_pick_idx;
    // Reset gating keeps ready low for every cycle rst_i is high.
    assign w_grant_en   = !rst_i && w_can_accept &&
                          ((r_state_q == ARB_LOCKED) || w_pick_found);
    assign w_xfer       = w_grant_en && req_valid_i[w_grant_idx];
    assign w_xfer_last  = req_last_i[w_grant_idx];

    // One-hot ready toward the granted requester only.
    always_comb begin
        req_ready_o = '0;
        if (w_grant_en) begin
            req_ready_o[w_grant_idx] = 1'b1;
        end
    end

    // Burst sequencing: a non-last beat locks the grant, a last beat
    // releases it and advances the pointer past the served requester.
    always_comb begin
        w_state_d    = r_state_q;
        w_ptr_d      = r_ptr_q;
        w_lock_idx_d = r_lock_idx_q;
        if (w_xfer) begin
            if (w_xfer_last) begin
                w_state_d = ARB_IDLE;
                w_ptr_d   = SELECT_WIDTH'(next_idx(32'(w_grant_idx), N));
            end else begin
                w_state_d    = ARB_LOCKED;
                w_lock_idx_d = w_grant_idx;
            end
        end
    end

    // State and output stage registers; a refill wins over a drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= ARB_IDLE;
            r_ptr_q       <= '0;
            r_lock_idx_q  <= '0;
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_src_q   <= '0;
            r_out_last_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_ptr_q      <= w_ptr_d;
            r_lock_idx_q <= w_lock_idx_d;
            if (w_xfer) begin
                r_out_valid_q <= 1'b1;
                r_out_data_q  <= w_mux_data;
                r_out_src_q   <= w_grant_idx;
                r_out_last_q  <= w_xfer_last;
            end else if (out_ready_i && r_out_valid_q) begin
                r_out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid_q;
    assign out_data_o  = r_out_data_q;
    assign out_src_o   = r_out_src_q;
    assign out_last_o  = r_out_last_q;
    assign busy_o      = (r_state_q == ARB_LOCKED);

endmodule : mux_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Directed and random stimulus for mux_rr_arbiter, checked
//               against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;
    localparam int N = 32;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [W-1:0]  req_data [N-1:0];
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [4:0]    out_src;
    logic          out_last;
    logic          busy;

    mux_rr_arbiter #(
        .SELECT_WIDTH (5),
        .DATA_WIDTH   (5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: plain integers describing the arbiter's rules.
    int        m_ptr;
    bit        m_locked;
    int        m_lock;
    bit        m_ov;
    logic [W-1:0] m_od;
    int        m_os;
    bit        m_ol;
    bit        m_xfer;
    int        m_g;
    int        beats;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict and check ready before the edge, then apply the
    // model's edge behaviour and check the registered outputs after it.
    task automatic step();
        int g;
        bit any;
        bit can;
        logic [N-1:0] exp_ready;
        #3;
        can = !m_ov || out_ready;
        any = 0;
        g   = 0;
        if (m_locked) begin
            any = 1;
            g   = m_lock;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!any && req_valid[(m_ptr + k) % N]) begin
                    any = 1;
                    g   = (m_ptr + k) % N;
                end
            end
        end
        exp_ready = (!rst && can && any) ? (32'd1 << g) : 32'd0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        m_xfer = (exp_ready != 0) && req_valid[g];
        m_g    = g;
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr = 0; m_locked = 0; m_lock = 0;
            m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
            m_xfer = 0;
        end else if (m_xfer) begin
            m_ov = 1;
            m_od = req_data[g];
            m_os = g;
            m_ol = req_last[g];
            if (req_last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked = 1;
                m_lock   = g;
            end
        end else if (out_ready && m_ov) begin
            m_ov = 0;
        end
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data",  64'(out_data),  64'(m_od));
        chk("out_src",   64'(out_src),   64'(m_os));
        chk("out_last",  64'(out_last),  64'(m_ol));
        chk("busy",      64'(busy),      64'(m_locked));
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) req_data[i] = 32'h1000_0000 | i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_ptr = 0; m_locked = 0; m_lock = 0;
        m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
        m_xfer = 0; m_g = 0;

        // Reset held two cycles with every requester valid.
        clear_reqs();
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '1;
        req_last  = '1;
        for (int i = 0; i < N; i++) req_data[i] = i;
        step();
        step();

        // Full rotation with single-beat bursts; first grant must be 0.
        rst = 1'b0;
        for (int c = 0; c < 34; c++) begin
            step();
            chk("rotation_src", 64'(out_src), 64'(c % N));
        end

        // Burst lock: requester 3 sends 4 beats while requester 4 waits.
        clear_reqs();
        beats = 0;
        req_valid[4] = 1'b1;
        req_last[4]  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_valid[3] = (beats < 4);
            req_last[3]  = (beats == 3);
            req_data[3]  = 32'h0300_0000 | beats;
            step();
            if (m_xfer && m_g == 3) beats++;
        end
        chk("burst_beats", 64'(beats), 64'd4);

        // Backpressure: hold 0xA5A5A5A5 while the consumer stalls.
        clear_reqs();
        req_valid[5] = 1'b1;
        req_last[5]  = 1'b1;
        req_data[5]  = 32'hA5A5_A5A5;
        step();
        req_data[5]  = 32'h1234_5678;
        req_valid[6] = 1'b1;
        req_last[6]  = 1'b1;
        out_ready    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_data", 64'(out_data), 64'hA5A5_A5A5);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();

        // Wrap/gap: bring ptr to 31, then 31 bursts with a valid gap.
        clear_reqs();
        req_valid[30] = 1'b1;
        req_last[30]  = 1'b1;
        step();
        clear_reqs();
        req_valid[31] = 1'b1;
        req_valid[0]  = 1'b1;
        req_last[0]   = 1'b1;
        step();
        chk("wrap_first", 64'(out_src), 64'd31);
        req_valid[31] = 1'b0;
        for (int c = 0; c < 3; c++) step();
        req_valid[31] = 1'b1;
        req_last[31]  = 1'b1;
        step();
        req_valid[31] = 1'b0;
        step();
        chk("wrap_next", 64'(out_src), 64'd0);

        // Reset while locked on 7 with a full, stalled output register.
        clear_reqs();
        req_valid[7] = 1'b1;
        step();
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = '1;
        req_last  = '1;
        step();
        chk("post_reset_grant", 64'(out_src), 64'd0);

        // Random traffic with occasional stalls and resets.
        for (int c = 0; c < 600; c++) begin
            req_valid = $urandom & $urandom;
            req_last  = $urandom & $urandom;
            for (int i = 0; i < N; i++) req_data[i] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux_rr_arbiter
`default_nettype wire
